// File: rtl/temp_poll_ctrl.sv
// Periodic LM75 poll sequencer in front of i2c_master: start pulse, fixed transfer window,
// signed temperature capture, sample counter and hysteresis alarm. Optional min/max tracking: TEMP_MINMAX_EN.
module temp_poll_ctrl #(
  parameter int         POLL_PERIOD = 50000,
  parameter int         XFER_CYCLES = 400,
  parameter logic [2:0] DEV_ADR     = 3'b101,
  parameter logic [7:0] PTR_REG     = 8'h00
) (
  input  logic       CLK,
  input  logic       RES,
  input  logic       en,
  input  logic [7:0] thr_high,
  input  logic [7:0] thr_low,
  input  logic [7:0] temp_input,
  output logic       start,
  output logic       rw,
  output logic [2:0] adr,
  output logic [7:0] temp_reg_d1,
  output logic [7:0] temp_val,
  output logic       temp_valid,
  output logic       alarm,
  output logic [7:0] sample_cnt,
  output logic       busy
`ifdef TEMP_MINMAX_EN
  ,
  output logic [7:0] temp_min,
  output logic [7:0] temp_max
`endif
);

  localparam int PW = $clog2(POLL_PERIOD);
  localparam int XW = (XFER_CYCLES > 1) ? $clog2(XFER_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, START, WAIT, CAPTURE} state_t;

  state_t          state, state_n;
  logic [PW-1:0]   period_cnt;
  logic [XW-1:0]   xfer_cnt;
  logic            period_done, xfer_done;

  assign period_done = (period_cnt == PW'(POLL_PERIOD - 1));
  assign xfer_done   = (xfer_cnt == XW'(XFER_CYCLES - 1));

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (en && period_done) state_n = START;
      START:   state_n = WAIT;
      WAIT:    if (xfer_done) state_n = CAPTURE;
      CAPTURE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so all flops sample the same pre-edge values.
  always_ff @(posedge CLK) begin
    if (!RES) state <= IDLE;
    else      state <= state_n;
  end

  // Period counter only runs while idling with en high; any other condition parks it at zero.
  always_ff @(posedge CLK) begin
    if (!RES) begin
      period_cnt <= '0;
      xfer_cnt   <= '0;
    end else begin
      if (state == IDLE && en && !period_done) period_cnt <= period_cnt + PW'(1);
      else                                     period_cnt <= '0;
      if (state == WAIT && !xfer_done) xfer_cnt <= xfer_cnt + XW'(1);
      else                             xfer_cnt <= '0;
    end
  end

  // Bus-side outputs are registered from the next state so they line up with the state itself.
  always_ff @(posedge CLK) begin
    if (!RES) begin
      start       <= 1'b0;
      busy        <= 1'b0;
      rw          <= 1'b1;
      adr         <= DEV_ADR;
      temp_reg_d1 <= PTR_REG;
    end else begin
      start       <= (state_n == START);
      busy        <= (state_n != IDLE);
      rw          <= 1'b1;
      adr         <= DEV_ADR;
      temp_reg_d1 <= PTR_REG;
    end
  end

  // Capture path; set beats clear when the thresholds overlap.
  always_ff @(posedge CLK) begin
    if (!RES) begin
      temp_val   <= 8'h00;
      temp_valid <= 1'b0;
      alarm      <= 1'b0;
      sample_cnt <= 8'h00;
    end else begin
      temp_valid <= (state == CAPTURE);
      if (state == CAPTURE) begin
        temp_val   <= temp_input;
        sample_cnt <= sample_cnt + 8'd1;
        if ($signed(temp_input) > $signed(thr_high))     alarm <= 1'b1;
        else if ($signed(temp_input) < $signed(thr_low)) alarm <= 1'b0;
      end
    end
  end

`ifdef TEMP_MINMAX_EN
  // Reset to the opposite extremes so the first capture overwrites both.
  always_ff @(posedge CLK) begin
    if (!RES) begin
      temp_min <= 8'h7F;
      temp_max <= 8'h80;
    end else if (state == CAPTURE) begin
      if ($signed(temp_input) < $signed(temp_min)) temp_min <= temp_input;
      if ($signed(temp_input) > $signed(temp_max)) temp_max <= temp_input;
    end
  end
`endif

endmodule

// File: tb/tb_temp_poll_ctrl.sv
// Directed bench for temp_poll_ctrl with POLL_PERIOD=10, XFER_CYCLES=20.
// Define TEMP_MINMAX_EN for the bench as well when building the min/max variant.
module tb_temp_poll_ctrl;

  logic       CLK = 1'b0;
  logic       RES;
  logic       en;
  logic [7:0] thr_high, thr_low, temp_input;
  logic       start, rw, temp_valid, alarm, busy;
  logic [2:0] adr;
  logic [7:0] temp_reg_d1, temp_val, sample_cnt;
`ifdef TEMP_MINMAX_EN
  logic [7:0] temp_min, temp_max;
`endif

  int total = 0;
  int bad   = 0;

  temp_poll_ctrl #(
    .POLL_PERIOD(10),
    .XFER_CYCLES(20),
    .DEV_ADR    (3'b101),
    .PTR_REG    (8'h00)
  ) dut (
    .CLK        (CLK),
    .RES        (RES),
    .en         (en),
    .thr_high   (thr_high),
    .thr_low    (thr_low),
    .temp_input (temp_input),
    .start      (start),
    .rw         (rw),
    .adr        (adr),
    .temp_reg_d1(temp_reg_d1),
    .temp_val   (temp_val),
    .temp_valid (temp_valid),
    .alarm      (alarm),
    .sample_cnt (sample_cnt),
    .busy       (busy)
`ifdef TEMP_MINMAX_EN
    ,
    .temp_min   (temp_min),
    .temp_max   (temp_max)
`endif
  );

  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=no_finish expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Entered one cycle into a start pulse; returns one cycle into the next start pulse (32 cycles).
  task automatic poll(input logic [7:0] sample, input logic exp_alarm, input logic [7:0] exp_cnt);
    temp_input = sample;
    tick(1);
    check("start_width", 32'(start), 0);
    tick(20);
    check("valid_early", 32'(temp_valid), 0);
    tick(1);
    check("valid", 32'(temp_valid), 1);
    check("temp_val", 32'(temp_val), 32'(sample));
    check("alarm", 32'(alarm), 32'(exp_alarm));
    check("sample_cnt", 32'(sample_cnt), 32'(exp_cnt));
    check("busy_idle", 32'(busy), 0);
    tick(10);
    check("next_start", 32'(start), 1);
  endtask

  initial begin
    bit seen;

    // Reset state
    RES = 1'b0; en = 1'b1;
    thr_high = 8'h1E; thr_low = 8'h1A; temp_input = 8'h19;
    tick(2);
    check("rst_start", 32'(start), 0);
    check("rst_temp_val", 32'(temp_val), 0);
    check("rst_valid", 32'(temp_valid), 0);
    check("rst_alarm", 32'(alarm), 0);
    check("rst_cnt", 32'(sample_cnt), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_rw", 32'(rw), 1);
    check("rst_adr", 32'(adr), 32'h5);
    check("rst_ptr", 32'(temp_reg_d1), 32'h00);
`ifdef TEMP_MINMAX_EN
    check("rst_min", 32'(temp_min), 32'h7F);
    check("rst_max", 32'(temp_max), 32'h80);
`endif

    // First start after 10 enabled idle cycles
    RES = 1'b1;
    tick(9);
    check("first_start_early", 32'(start), 0);
    tick(1);
    check("first_start", 32'(start), 1);
    check("busy_start", 32'(busy), 1);

    // Capture latency, repeat interval and hysteresis
    poll(8'h19, 1'b0, 8'd1);
    poll(8'h1F, 1'b1, 8'd2);
    poll(8'h1B, 1'b1, 8'd3);
    poll(8'h19, 1'b0, 8'd4);

    // Signed compares, overlapping thresholds and negative boundaries
    thr_high = 8'h05;
    poll(8'hF6, 1'b0, 8'd5);
    thr_low = 8'h0A;
    poll(8'h07, 1'b1, 8'd6);
    thr_low = 8'hF0;
    poll(8'hF0, 1'b1, 8'd7);
    poll(8'hEF, 1'b0, 8'd8);
`ifdef TEMP_MINMAX_EN
    check("min_after8", 32'(temp_min), 32'hEF);
    check("max_after8", 32'(temp_max), 32'h1F);
`endif

    // en dropped during WAIT: transaction completes, no further start
    temp_input = 8'h2A;
    tick(5);
    en = 1'b0;
    tick(17);
    check("en_drop_valid", 32'(temp_valid), 1);
    check("en_drop_val", 32'(temp_val), 32'h2A);
    check("en_drop_cnt", 32'(sample_cnt), 9);
    check("en_drop_alarm", 32'(alarm), 1);
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick(1);
      if (start) seen = 1'b1;
    end
    check("en_low_no_start", 32'(seen), 0);

    // en rising: full POLL_PERIOD before the next start
    en = 1'b1;
    tick(9);
    check("en_rise_early", 32'(start), 0);
    tick(1);
    check("en_rise_start", 32'(start), 1);

    // Reset during WAIT aborts the transaction
    tick(5);
    RES = 1'b0;
    tick(2);
    check("abort_start", 32'(start), 0);
    check("abort_busy", 32'(busy), 0);
    RES = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (temp_valid) seen = 1'b1;
    end
    check("abort_no_valid", 32'(seen), 0);
    check("abort_cnt", 32'(sample_cnt), 0);
    check("abort_temp_val", 32'(temp_val), 0);
    check("abort_alarm", 32'(alarm), 0);
    check("abort_restart", 32'(start), 1);

    // 256 captures wrap the counter; alarm can never change with these thresholds
    thr_high = 8'h7F; thr_low = 8'h80;
    for (int k = 1; k <= 256; k++) poll(8'(k), 1'b0, 8'(k));
    check("wrap_cnt", 32'(sample_cnt), 0);
`ifdef TEMP_MINMAX_EN
    check("wrap_min", 32'(temp_min), 32'h80);
    check("wrap_max", 32'(temp_max), 32'h7F);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
